// File: rtl/x2050_pkg.sv
// Shared definitions for the 2050 mover output writer: WM field encodings,
// big-endian byte-lane positions within M, and the channel parity helper.
package x2050_pkg;

  typedef enum logic [1:0] {
    WM_NONE    = 2'd0,
    WM_LB      = 2'd1,
    WM_MB      = 2'd2,
    WM_BOTH_IO = 2'd3
  } wm_e;

  // Byte 0 is the most significant lane of M.
  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic [31:0] set_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0:    r[LANE0_LSB +: 8] = b;
      2'd1:    r[LANE1_LSB +: 8] = b;
      2'd2:    r[LANE2_LSB +: 8] = b;
      default: r[LANE3_LSB +: 8] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/x2050wmv_if.sv
// Multiplexor-channel buffer-out link: 9-bit data+parity word with valid/ready.
interface x2050wmv_if;
  logic [8:0] mpx_buffer_out_bus;
  logic       mpx_valid;
  logic       mpx_ready;

  modport master (output mpx_buffer_out_bus, output mpx_valid, input mpx_ready);
  modport slave  (input mpx_buffer_out_bus, input mpx_valid, output mpx_ready);
endinterface

// File: rtl/x2050_mpxbuf.sv
// 9-bit buffer-out FIFO; head is registered state, pop on valid & ready.
// A push into a full queue survives only if a pop frees a slot the same cycle.
module x2050_mpxbuf #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic [8:0] i_push_dat,
  input  logic       i_rdy,
  input  logic       i_ovr_clr,
  output logic [8:0] o_head,
  output logic       o_vld,
  output logic       o_full,
  output logic       o_overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rptr, r_wptr;
  logic [AW:0]   r_cnt;
  logic          r_overrun;
  logic          w_pop, w_push_ok, w_ovr_set;

  assign o_vld     = (r_cnt != '0);
  assign o_full    = (r_cnt == CNT_FULL);
  assign o_head    = o_vld ? r_mem[r_rptr] : 9'h000;
  assign o_overrun = r_overrun;

  assign w_pop     = o_vld & i_rdy;
  assign w_push_ok = i_push & (~o_full | w_pop);
  assign w_ovr_set = i_push & o_full & ~w_pop;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      // A fresh drop outranks a clear in the same cycle.
      if (w_ovr_set)      r_overrun <= 1'b1;
      else if (i_ovr_clr) r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_push_dat;
  end

endmodule

// File: rtl/x2050wmv.sv
// Mover output writer: lands W in an M byte lane (LB/MB) or, in I/O mode,
// queues W with odd parity toward the multiplexor channel.
module x2050wmv
  import x2050_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_io_mode,
  input  logic [1:0]  i_wm,
  input  logic [7:0]  i_w_reg,
  input  logic [1:0]  i_lb_reg,
  input  logic [1:0]  i_mb_reg,
  input  logic        i_m_load,
  input  logic [31:0] i_m_in,
  input  logic        i_overrun_clr,
  output logic [31:0] o_m_reg,
  output logic        o_full,
  output logic        o_overrun,
  x2050wmv_if.master  mpx
);
  logic [31:0] r_m_reg;
  logic [31:0] w_m_nxt;
  logic [1:0]  w_idx;
  logic        w_wr_lb, w_wr_mb, w_push;

  // I/O mode folds WM=2 onto the push encoding.
  assign w_idx   = i_wm | {1'b0, i_io_mode & i_wm[1]};
  assign w_wr_lb = (w_idx == WM_LB) | ((w_idx == WM_BOTH_IO) & ~i_io_mode);
  assign w_wr_mb = (w_idx == WM_MB) | ((w_idx == WM_BOTH_IO) & ~i_io_mode);
  assign w_push  = (w_idx == WM_BOTH_IO) & i_io_mode;

  always_comb begin
    w_m_nxt = i_m_load ? i_m_in : r_m_reg;
    if (w_wr_mb) w_m_nxt = set_lane(w_m_nxt, i_mb_reg, i_w_reg);
    if (w_wr_lb) w_m_nxt = set_lane(w_m_nxt, i_lb_reg, i_w_reg);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_m_reg <= '0;
    else          r_m_reg <= w_m_nxt;
  end

  assign o_m_reg = r_m_reg;

  x2050_mpxbuf #(.FIFO_DEPTH(FIFO_DEPTH)) u_mpxbuf (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_dat ({odd_par(i_w_reg), i_w_reg}),
    .i_rdy      (mpx.mpx_ready),
    .i_ovr_clr  (i_overrun_clr),
    .o_head     (mpx.mpx_buffer_out_bus),
    .o_vld      (mpx.mpx_valid),
    .o_full     (o_full),
    .o_overrun  (o_overrun)
  );

endmodule

// File: tb/tb_x2050wmv.sv
// Bench for x2050wmv: directed M-lane writes plus a queue scoreboard for the
// buffer-out FIFO (expected entries queued on push, compared at the head).
module tb_x2050wmv;
  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_mode, m_load, ovr_clr;
  logic [1:0]  wm, lb, mb;
  logic [7:0]  w;
  logic [31:0] m_in;
  logic [31:0] m_reg;
  logic        full, overrun;

  x2050wmv_if mpx ();

  x2050wmv #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_io_mode     (io_mode),
    .i_wm          (wm),
    .i_w_reg       (w),
    .i_lb_reg      (lb),
    .i_mb_reg      (mb),
    .i_m_load      (m_load),
    .i_m_in        (m_in),
    .i_overrun_clr (ovr_clr),
    .o_m_reg       (m_reg),
    .o_full        (full),
    .o_overrun     (overrun),
    .mpx           (mpx.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [8:0]  q[$];
  logic        exp_ovr;
  logic [31:0] exp_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock: check head before the edge, advance the model, check state after.
  task automatic cycle();
    logic pop_m, push_m, full_b;
    chk("valid", {31'd0, mpx.mpx_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) chk("head", {23'd0, mpx.mpx_buffer_out_bus}, {23'd0, q[0]});
    else               chk("bus_idle", {23'd0, mpx.mpx_buffer_out_bus}, 32'd0);
    pop_m  = (q.size() != 0) && mpx.mpx_ready;
    push_m = io_mode && wm[1];
    full_b = (q.size() == FIFO_DEPTH);
    @(posedge clk); #1;
    if (pop_m) void'(q.pop_front());
    if (push_m && (!full_b || pop_m)) q.push_back({~^w, w});
    if (push_m && full_b && !pop_m) exp_ovr = 1'b1;
    else if (ovr_clr)               exp_ovr = 1'b0;
    chk("full", {31'd0, full}, {31'd0, q.size() == FIFO_DEPTH});
    chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    chk("m_reg", m_reg, exp_m);
  endtask

  initial begin
    rst_n = 1'b0; io_mode = 1'b0; m_load = 1'b0; ovr_clr = 1'b0;
    wm = 2'd0; lb = 2'd0; mb = 2'd0; w = 8'h00; m_in = 32'h0;
    mpx.mpx_ready = 1'b0;
    exp_ovr = 1'b0; exp_m = 32'h0;
    #12;
    chk("rst_m", m_reg, 32'h0);
    chk("rst_valid", {31'd0, mpx.mpx_valid}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;

    m_load = 1'b1; m_in = 32'h11223344; exp_m = 32'h11223344; cycle();
    m_load = 1'b0;
    wm = 2'd1; lb = 2'd2; w = 8'hAA; exp_m = 32'h1122AA44; cycle();
    wm = 2'd2; mb = 2'd0; w = 8'h55; exp_m = 32'h5522AA44; cycle();
    wm = 2'd3; lb = 2'd1; mb = 2'd3; w = 8'h0F; exp_m = 32'h550FAA0F; cycle();
    wm = 2'd3; lb = 2'd0; mb = 2'd0; w = 8'hF0; exp_m = 32'hF00FAA0F; cycle();
    m_load = 1'b1; m_in = 32'h0; wm = 2'd1; lb = 2'd3; w = 8'h7E;
    exp_m = 32'h0000007E; cycle();
    m_load = 1'b0;

    // I/O mode: M must not move even with lanes pointing elsewhere.
    io_mode = 1'b1; mb = 2'd0; lb = 2'd1;
    wm = 2'd2; w = 8'h00; cycle();
    wm = 2'd3; w = 8'h01; cycle();
    chk("head_100", {23'd0, mpx.mpx_buffer_out_bus}, 32'h100);
    wm = 2'd3; w = 8'hFF; cycle();
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    wm = 2'd3; w = 8'h03; mpx.mpx_ready = 1'b1; cycle();
    wm = 2'd0; cycle();
    cycle();
    cycle();
    chk("drained", {31'd0, mpx.mpx_valid}, 32'd0);

    ovr_clr = 1'b1; cycle();
    ovr_clr = 1'b0;
    // Refill, then a drop coinciding with a clear: the set must win.
    mpx.mpx_ready = 1'b0;
    wm = 2'd3; w = 8'h80; cycle();
    w = 8'h7F; cycle();
    w = 8'h11; ovr_clr = 1'b1; cycle();
    ovr_clr = 1'b0; wm = 2'd0;
    chk("ovr_set_wins", {31'd0, overrun}, 32'd1);

    exp_m = 32'h0000007E;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m", m_reg, 32'h0);
    chk("arst_valid", {31'd0, mpx.mpx_valid}, 32'd0);
    chk("arst_bus", {23'd0, mpx.mpx_buffer_out_bus}, 32'd0);
    chk("arst_full", {31'd0, full}, 32'd0);
    chk("arst_ovr", {31'd0, overrun}, 32'd0);
    q.delete(); exp_ovr = 1'b0; exp_m = 32'h0;
    @(negedge clk); rst_n = 1'b1;
    mpx.mpx_ready = 1'b1;
    @(posedge clk); #1;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
